hex_calc_ctrl: RTL
==================

# hex_calc_ctrl

Sequencing controller for the hexadecimal calculator datapath. It turns a single raw ENTER pushbutton into a fixed entry sequence: operand A, then operand B plus operation, then compute and show. It issues one-cycle load strobes to the A, B and result registers, holds the selected ALU operation, and drives per-field display blanking and blinking. It sits between the board keys/switches and the operand/result registers and seven-segment decoders in the top level.

## Interface
- LOCKOUT, default 1_000_000: clk cycles during which further presses are ignored after an accepted press; 0 disables lockout.
- BLINK_DIV, default 12_500_000: clk cycles per blink half-period; must be ≥ 2.
- CNT_W, default 24: width of the lockout and blink counters; LOCKOUT and BLINK_DIV must fit.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- enter_n  in  1  raw ENTER pushbutton, active-low, asynchronous to clk.
- op_in  in  2  operation switches: 00 add, 01 sub (A−B), 10 AND, 11 OR.
- a_en  out  1  one-cycle load strobe for the A register.
- b_en  out  1  one-cycle load strobe for the B register.
- res_en  out  1  one-cycle load strobe for the result register.
- alu_op  out  2  latched operation presented to the datapath.
- phase  out  2  current state encoding, for the LEDs.
- blank_a, blank_b, blank_res  out  1 each  display blanking for the A, B and result fields; 1 = digit off.

## Operation
- Input conditioning: 3-flop chain s1←enter_n, s2←s1, s3←s2. press = s3 & ~s2 (falling edge).
- accept = press & (lock_cnt == 0). An accepted press loads lock_cnt ← LOCKOUT; lock_cnt then decrements to 0.
- A press during lockout is discarded, not queued.
- States and transitions; phase carries the encoding:
  - S_A (00): on accept, pulse a_en and go to S_B.
  - S_B (01): on accept, pulse b_en, latch alu_op ← op_in, go to S_EX.
  - S_EX (10): one cycle only. Pulse res_en, go to S_SHOW. Presses are ignored.
  - S_SHOW (11): on accept, go to S_A with no strobe. A, B and the result are retained downstream.
- Blanking:
  - S_A: blank_b = blank_res = 1; blank_a = blink.
  - S_B: blank_res = 1; blank_a = 0; blank_b = blink.
  - S_EX and S_SHOW: all blank outputs 0.
- blink: phase flag of the blink counter when blinking is compiled in; otherwise 0.
- alu_op changes only on the accepted press in S_B.
- At most one of a_en, b_en and res_en is high in any cycle.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Press latency:
  - enter_n is low at rising edge N, having been high for ≥ 3 prior edges.
  - press is high in the cycle after edge N+1.
  - The strobe and state change register at edge N+2; the strobe is high for exactly that one cycle.
- res_en registers at the edge following b_en, so the two are one cycle apart. The result register therefore loads one cycle after B.
- Reset (sampled with reset = 0 at a clk edge), at the next edge:
  - State S_A; phase = 00.
  - a_en = b_en = res_en = 0; alu_op = 00.
  - blank_a = 0, blank_b = blank_res = 1.
  - lock_cnt = 0; blink counter = 0 and blink phase = 0.
  - s1..s3 = 0, i.e. treated as pressed, so a button held across reset release produces no press until it is released and pressed again.
- Reset mid-sequence, including in S_EX: any pending strobe is suppressed and the state returns to S_A.
- Lockout: an accept at edge M blocks presses through edge M+LOCKOUT; a press is next accepted once lock_cnt has reached 0.

## Configuration
- HEX_CALC_CTRL_BLINK_EN defined:
  - A CNT_W counter runs 0..BLINK_DIV−1 continuously, wraps to 0, and toggles the blink flag at each wrap.
  - The field under entry is blanked while the flag is 1.
- Undefined:
  - No blink counter is built and blink is constant 0.
  - The field under entry is shown steadily; the other blanking rules are unchanged.

## Test plan
- Reset, then LOCKOUT=4: press, wait, press with op_in=01, wait, press. Expect:
  - a_en at edge N+2 of the first press.
  - b_en with alu_op=01.
  - res_en the next cycle.
  - phase sequence 00→01→10→11→00.
- Two presses 2 cycles apart with LOCKOUT=4: only the first is accepted; one a_en pulse; phase = 01.
- Hold enter_n low across reset release: no strobe and phase stays 00. Release then press: a_en fires once.
- Assert reset in the cycle b_en is high: res_en never pulses; phase = 00, alu_op = 00, blank_b = blank_res = 1.
- BLINK_EN, BLINK_DIV=3, in S_A: blank_a toggles every 3 cycles and blank_b stays 1. Without the macro, blank_a stays 0.
- Change op_in in S_SHOW and S_A: alu_op stays at the value latched in S_B.

Source files
------------

// File: rtl/hex_calc_ctrl.sv
// Entry sequencer for the hex calculator: ENTER steps through A, B+op, compute, show.
// Define HEX_CALC_CTRL_BLINK_EN to blink the field under entry.
module hex_calc_ctrl #(
  parameter int LOCKOUT   = 1_000_000,
  parameter int BLINK_DIV = 12_500_000,
  parameter int CNT_W     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_n,
  input  logic [1:0] op_in,
  output logic       a_en,
  output logic       b_en,
  output logic       res_en,
  output logic [1:0] alu_op,
  output logic [1:0] phase,
  output logic       blank_a,
  output logic       blank_b,
  output logic       blank_res
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EX   = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             press, accept;
  logic [CNT_W-1:0] lock_cnt;
  logic             a_nx, b_nx, res_nx;
  logic             blink;

  // Synchronizer clears to 0 so a button held through reset reads as already pressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= enter_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press  = s3 & ~s2;
  assign accept = press & (lock_cnt == '0) & (state != S_EX);

  always_ff @(posedge clk) begin
    if (!reset)              lock_cnt <= '0;
    else if (accept)         lock_cnt <= CNT_W'(LOCKOUT);
    else if (lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
  end

  always_comb begin
    state_nx = state;
    a_nx     = 1'b0;
    b_nx     = 1'b0;
    res_nx   = 1'b0;
    case (state)
      S_A:    if (accept) begin a_nx = 1'b1; state_nx = S_B; end
      S_B:    if (accept) begin b_nx = 1'b1; state_nx = S_EX; end
      S_EX:   begin res_nx = 1'b1; state_nx = S_SHOW; end
      S_SHOW: if (accept) state_nx = S_A;
      default: state_nx = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_A;
      a_en   <= 1'b0;
      b_en   <= 1'b0;
      res_en <= 1'b0;
      alu_op <= 2'b00;
    end else begin
      state  <= state_nx;
      a_en   <= a_nx;
      b_en   <= b_nx;
      res_en <= res_nx;
      if (state == S_B && accept) alu_op <= op_in;
    end
  end

`ifdef HEX_CALC_CTRL_BLINK_EN
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign phase = state;

  // Decoded from registers only, so no input reaches these combinationally.
  always_comb begin
    blank_a   = 1'b0;
    blank_b   = 1'b0;
    blank_res = 1'b0;
    case (state)
      S_A: begin
        blank_a   = blink;
        blank_b   = 1'b1;
        blank_res = 1'b1;
      end
      S_B: begin
        blank_b   = blink;
        blank_res = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
